// File: rtl/retire_unit_pkg.sv
// Shared rv32i types for the commit stage: ROB-head entry, RVFI commit
// record and the registered free-list push slot.
package retire_unit_pkg;

  localparam int SS         = 2;
  localparam int PR_ENTRIES = 64;
  localparam int PR_W       = $clog2(PR_ENTRIES);
  localparam int ROB_DEPTH  = 8;
  localparam int ROB_W      = $clog2(ROB_DEPTH);
  localparam int FL_CNT_W   = $clog2(PR_ENTRIES) + 1;

  typedef struct packed {
    logic             commit;
    logic [ROB_W-1:0] idx;
  } rob_info_t;

  typedef struct packed {
    logic [4:0]      isa_rd;
    logic [PR_W-1:0] rd;
  } rat_info_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    rob_info_t rob;
    rat_info_t rat;
    rvfi_t     rvfi;
  } super_dispatch_t;

  typedef struct packed {
    logic            valid;
    logic [PR_W-1:0] free_reg;
  } retire_slot_t;

endpackage

// File: rtl/retire_hazard_fix.sv
// Intra-group same-rd forwarding: picks the register each retiring lane
// frees and masks RRAT writes so only the youngest writer of an rd lands.
module retire_hazard_fix
  import retire_unit_pkg::*;
(
  input  logic [SS-1:0]   pop,
  input  logic [4:0]      isa_rd   [SS],
  input  logic [PR_W-1:0] new_phys [SS],
  input  logic [PR_W-1:0] old_phys [SS],
  output logic [SS-1:0]   rrat_we,
  output logic [PR_W-1:0] free_reg [SS]
);

  // x0 frees its own allocation; otherwise the youngest older same-rd lane wins
  always_comb begin
    rrat_we = '0;
    for (int i = 0; i < SS; i++) begin
      free_reg[i] = (isa_rd[i] == 5'd0) ? new_phys[i] : old_phys[i];
    end
    for (int i = 0; i < SS; i++) begin
      if (isa_rd[i] != 5'd0) begin
        for (int j = 0; j < SS; j++) begin
          if (j < i && pop[j] && isa_rd[j] == isa_rd[i]) free_reg[i] = new_phys[j];
        end
      end
      rrat_we[i] = pop[i] && (isa_rd[i] != 5'd0);
      for (int k = 0; k < SS; k++) begin
        if (k > i && pop[k] && isa_rd[k] == isa_rd[i]) rrat_we[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_unit.sv
// In-order commit stage at the ROB head. Optional RVFI commit records and
// the order counter are built only when RETIRE_RVFI_EN is defined.
module retire_unit
  import retire_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  super_dispatch_t     rob_head       [SS],
  input  logic [SS-1:0]       rob_head_valid,
  output logic [SS-1:0]       rob_pop,
  output logic [4:0]          rrat_isa_rd    [SS],
  input  logic [PR_W-1:0]     rrat_old_phys  [SS],
  output logic [SS-1:0]       rrat_we,
  output logic [PR_W-1:0]     rrat_new_phys  [SS],
  input  logic [FL_CNT_W-1:0] fl_space,
  output logic [SS-1:0]       fl_push,
  output logic [PR_W-1:0]     fl_push_reg    [SS],
  output rvfi_t               commit_rvfi    [SS],
  output logic                store_committed
);

  logic [SS-1:0]       pop;
  logic [FL_CNT_W-1:0] n_retire;
  logic                blocked;
  logic [4:0]          isa_rd   [SS];
  logic [PR_W-1:0]     new_phys [SS];
  logic [PR_W-1:0]     free_reg [SS];
  logic [SS-1:0]       we_mask;
  retire_slot_t        slot_d   [SS];
  retire_slot_t        slot_q   [SS];
  logic                store_d, store_q;
  logic                unused_bits;

  // prefix-contiguous lane selection; each retiring lane needs one free-list slot
  always_comb begin
    pop      = '0;
    n_retire = '0;
    blocked  = !rst_n;
    for (int i = 0; i < SS; i++) begin
      isa_rd[i]   = rob_head[i].rat.isa_rd;
      new_phys[i] = rob_head[i].rat.rd;
      if (!blocked && rob_head_valid[i] && rob_head[i].rob.commit && fl_space > n_retire) begin
        pop[i]   = 1'b1;
        n_retire = n_retire + FL_CNT_W'(1);
      end else begin
        blocked = 1'b1;
      end
    end
  end

  retire_hazard_fix u_hazard (
    .pop      (pop),
    .isa_rd   (isa_rd),
    .new_phys (new_phys),
    .old_phys (rrat_old_phys),
    .rrat_we  (we_mask),
    .free_reg (free_reg)
  );

  assign rob_pop       = pop;
  assign rrat_we       = we_mask;
  assign rrat_isa_rd   = isa_rd;
  assign rrat_new_phys = new_phys;

  // next-cycle free-list pushes and store-commit flag
  always_comb begin
    store_d     = 1'b0;
    unused_bits = 1'b0;
    for (int i = 0; i < SS; i++) begin
      slot_d[i].valid    = pop[i];
      slot_d[i].free_reg = free_reg[i];
      if (pop[i] && rob_head[i].rvfi.mem_wmask != 4'd0) store_d = 1'b1;
      unused_bits = unused_bits ^ (^rob_head[i]);
    end
  end

  // push pipeline register; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) slot_q[i] <= '0;
      store_q <= 1'b0;
    end else begin
      for (int i = 0; i < SS; i++) slot_q[i] <= slot_d[i];
      store_q <= store_d;
    end
  end

  // unpack push slots onto the free-list port
  always_comb begin
    for (int i = 0; i < SS; i++) begin
      fl_push[i]     = slot_q[i].valid;
      fl_push_reg[i] = slot_q[i].free_reg;
    end
  end

  assign store_committed = store_q;

`ifdef RETIRE_RVFI_EN
  logic [63:0] order_d, order_q;
  rvfi_t       rvfi_d [SS];
  rvfi_t       rvfi_q [SS];

  // stamp each retiring lane with its program-order index
  always_comb begin
    order_d = order_q + 64'(n_retire);
    for (int i = 0; i < SS; i++) begin
      rvfi_d[i]       = rob_head[i].rvfi;
      rvfi_d[i].valid = pop[i];
      rvfi_d[i].order = order_q + 64'(i);
    end
  end

  // commit record and order counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= '0;
      for (int i = 0; i < SS; i++) rvfi_q[i] <= '0;
    end else begin
      order_q <= order_d;
      for (int i = 0; i < SS; i++) rvfi_q[i] <= rvfi_d[i];
    end
  end

  assign commit_rvfi = rvfi_q;
`else
  // feature disabled: commit records held at zero
  always_comb begin
    for (int i = 0; i < SS; i++) commit_rvfi[i] = '0;
  end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Self-checking bench for retire_unit (honours RETIRE_RVFI_EN if defined).
module tb_retire_unit;
  import retire_unit_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  super_dispatch_t     rob_head [SS];
  logic [SS-1:0]       rob_head_valid;
  logic [SS-1:0]       rob_pop;
  logic [4:0]          rrat_isa_rd [SS];
  logic [PR_W-1:0]     rrat_old_phys [SS];
  logic [SS-1:0]       rrat_we;
  logic [PR_W-1:0]     rrat_new_phys [SS];
  logic [FL_CNT_W-1:0] fl_space;
  logic [SS-1:0]       fl_push;
  logic [PR_W-1:0]     fl_push_reg [SS];
  rvfi_t               commit_rvfi [SS];
  logic                store_committed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  retire_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rob_head       (rob_head),
    .rob_head_valid (rob_head_valid),
    .rob_pop        (rob_pop),
    .rrat_isa_rd    (rrat_isa_rd),
    .rrat_old_phys  (rrat_old_phys),
    .rrat_we        (rrat_we),
    .rrat_new_phys  (rrat_new_phys),
    .fl_space       (fl_space),
    .fl_push        (fl_push),
    .fl_push_reg    (fl_push_reg),
    .commit_rvfi    (commit_rvfi),
    .store_committed(store_committed)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SS-1:0]   m_pop, m_we;
  logic [PR_W-1:0] m_free [SS];
  int              m_n;
  logic            m_store;

  logic [SS-1:0]   e_push_v = '0;
  logic [PR_W-1:0] e_push_reg [SS];
  logic            e_store = 1'b0;
  logic [63:0]     e_order = '0;
  logic [63:0]     e_ord0 = '0;
  logic [31:0]     e_wdata [SS];

  // Walk the retiring group in program order against a scratch copy of the
  // architectural map; the last writer of each rd is the one the RRAT keeps.
  function automatic void model_eval();
    logic [PR_W-1:0] cur [32];
    logic [31:0]     seen;
    int              last [32];
    int              ready;
    int              rd;
    m_pop = '0; m_we = '0; m_n = 0; m_store = 1'b0; seen = '0;
    for (int i = 0; i < SS; i++) m_free[i] = '0;
    for (int r = 0; r < 32; r++) begin cur[r] = '0; last[r] = -1; end
    if (!rst_n) return;
    ready = 0;
    while (ready < SS && rob_head_valid[ready] && rob_head[ready].rob.commit) ready++;
    m_n = (ready < int'(fl_space)) ? ready : int'(fl_space);
    for (int i = 0; i < m_n; i++) begin
      m_pop[i] = 1'b1;
      rd = int'(rob_head[i].rat.isa_rd);
      if (rd == 0) m_free[i] = rob_head[i].rat.rd;
      else begin
        m_free[i] = seen[rd] ? cur[rd] : rrat_old_phys[i];
        cur[rd]   = rob_head[i].rat.rd;
        seen[rd]  = 1'b1;
        last[rd]  = i;
      end
      if (rob_head[i].rvfi.mem_wmask != 4'd0) m_store = 1'b1;
    end
    for (int r = 1; r < 32; r++) if (last[r] >= 0) m_we[last[r]] = 1'b1;
  endfunction

  // model's registered view (pushes, store flag, order)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_push_v <= '0; e_store <= 1'b0; e_order <= '0; e_ord0 <= '0;
    end else begin
      e_push_v   <= m_pop;
      e_push_reg <= m_free;
      e_store    <= m_store;
      e_ord0     <= e_order;
      e_order    <= e_order + 64'(m_n);
      for (int i = 0; i < SS; i++) e_wdata[i] <= rob_head[i].rvfi.rd_wdata;
    end
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    model_eval();
    chk("rob_pop", 64'(rob_pop), 64'(m_pop));
    chk("rrat_we", 64'(rrat_we), 64'(m_we));
    chk("fl_push", 64'(fl_push), 64'(e_push_v));
    chk("store_committed", 64'(store_committed), 64'(e_store));
    for (int i = 0; i < SS; i++) begin
      if (m_pop[i]) chk("rrat_isa_rd", 64'(rrat_isa_rd[i]), 64'(rob_head[i].rat.isa_rd));
      if (m_we[i]) chk("rrat_new_phys", 64'(rrat_new_phys[i]), 64'(rob_head[i].rat.rd));
      if (e_push_v[i]) chk("fl_push_reg", 64'(fl_push_reg[i]), 64'(e_push_reg[i]));
`ifdef RETIRE_RVFI_EN
      chk("rvfi_valid", 64'(commit_rvfi[i].valid), 64'(e_push_v[i]));
      if (e_push_v[i]) begin
        chk("rvfi_order", commit_rvfi[i].order, e_ord0 + 64'(i));
        chk("rvfi_rd_wdata", 64'(commit_rvfi[i].rd_wdata), 64'(e_wdata[i]));
      end
`else
      chk("rvfi_tied_zero", 64'(|commit_rvfi[i]), 64'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_lane(input int l, input logic v, input logic c, input logic [4:0] rd,
                          input logic [PR_W-1:0] prd, input logic [PR_W-1:0] old, input logic [3:0] wm);
    rob_head[l]                = '0;
    rob_head_valid[l]          = v;
    rob_head[l].rob.commit     = c;
    rob_head[l].rat.isa_rd     = rd;
    rob_head[l].rat.rd         = prd;
    rob_head[l].rvfi.rd_addr   = rd;
    rob_head[l].rvfi.rd_wdata  = 32'(prd) + 32'h1000;
    rob_head[l].rvfi.mem_wmask = wm;
    rrat_old_phys[l]           = old;
  endtask

  task automatic idle();
    set_lane(0, 1'b0, 1'b0, 5'd0, '0, '0, 4'd0);
    set_lane(1, 1'b0, 1'b0, 5'd0, '0, '0, 4'd0);
    fl_space = FL_CNT_W'(8);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    idle();
    set_lane(0, 1'b1, 1'b1, 5'd5, 6'd40, 6'd5, 4'd0);
    cyc();
    chk("reset_rob_pop", 64'(rob_pop), 64'd0);
    chk("reset_fl_push", 64'(fl_push), 64'd0);
    chk("reset_store", 64'(store_committed), 64'd0);
    cyc();
    rst_n = 1'b1;

    // single retire, rd=x5
    set_lane(0, 1'b1, 1'b1, 5'd5, 6'd40, 6'd5, 4'd0);
    at_neg();
    chk("v1_pop", 64'(rob_pop), 64'b01);
    chk("v1_we", 64'(rrat_we), 64'b01);
    chk("v1_new_phys", 64'(rrat_new_phys[0]), 64'd40);
    cyc(); idle();
    chk("v1_push", 64'(fl_push), 64'b01);
    chk("v1_push_reg", 64'(fl_push_reg[0]), 64'd5);
`ifdef RETIRE_RVFI_EN
    chk("v1_order", commit_rvfi[0].order, 64'd0);
`endif

    // older lane not committed blocks younger
    set_lane(0, 1'b1, 1'b0, 5'd3, 6'd20, 6'd3, 4'd0);
    set_lane(1, 1'b1, 1'b1, 5'd4, 6'd21, 6'd4, 4'd0);
    at_neg();
    chk("v2_pop", 64'(rob_pop), 64'b00);
    cyc(); idle();
    chk("v2_push", 64'(fl_push), 64'b00);

    // same rd in both lanes
    set_lane(0, 1'b1, 1'b1, 5'd7, 6'd33, 6'd7, 4'd0);
    set_lane(1, 1'b1, 1'b1, 5'd7, 6'd34, 6'd7, 4'd0);
    at_neg();
    chk("v3_pop", 64'(rob_pop), 64'b11);
    chk("v3_we", 64'(rrat_we), 64'b10);
    chk("v3_new_phys", 64'(rrat_new_phys[1]), 64'd34);
    cyc(); idle();
    chk("v3_push", 64'(fl_push), 64'b11);
    chk("v3_push_reg0", 64'(fl_push_reg[0]), 64'd7);
    chk("v3_push_reg1", 64'(fl_push_reg[1]), 64'd33);
`ifdef RETIRE_RVFI_EN
    chk("v3_order1", commit_rvfi[1].order, 64'd2);
`endif

    // rd = x0 frees its own allocation
    set_lane(0, 1'b1, 1'b1, 5'd0, 6'd50, 6'd0, 4'd0);
    at_neg();
    chk("v4_we", 64'(rrat_we), 64'b00);
    cyc(); idle();
    chk("v4_push_reg", 64'(fl_push_reg[0]), 64'd50);

    // fl_space = 1 admits one lane, the other follows
    fl_space = FL_CNT_W'(1);
    set_lane(0, 1'b1, 1'b1, 5'd1, 6'd10, 6'd1, 4'd0);
    set_lane(1, 1'b1, 1'b1, 5'd2, 6'd11, 6'd2, 4'd0);
    at_neg();
    chk("v5_pop", 64'(rob_pop), 64'b01);
    cyc();
    fl_space = FL_CNT_W'(8);
    set_lane(0, 1'b1, 1'b1, 5'd2, 6'd11, 6'd2, 4'd0);
    set_lane(1, 1'b0, 1'b0, 5'd0, '0, '0, 4'd0);
    chk("v5_push_reg_a", 64'(fl_push_reg[0]), 64'd1);
    at_neg();
    chk("v5_pop_b", 64'(rob_pop), 64'b01);
    chk("v5_new_phys_b", 64'(rrat_new_phys[0]), 64'd11);
    cyc(); idle();
    chk("v5_push_reg_b", 64'(fl_push_reg[0]), 64'd2);

    // store commit pulse
    set_lane(0, 1'b1, 1'b1, 5'd0, 6'd20, 6'd0, 4'hf);
    at_neg();
    chk("v6_store_before", 64'(store_committed), 64'd0);
    cyc(); idle();
    chk("v6_store", 64'(store_committed), 64'd1);
    cyc();
    chk("v6_store_after", 64'(store_committed), 64'd0);

    // no free-list space
    fl_space = FL_CNT_W'(0);
    set_lane(0, 1'b1, 1'b1, 5'd3, 6'd12, 6'd3, 4'd0);
    set_lane(1, 1'b1, 1'b1, 5'd4, 6'd13, 6'd4, 4'd0);
    at_neg();
    chk("v7_pop", 64'(rob_pop), 64'b00);
    cyc(); idle();

    // reset mid-stream
    set_lane(0, 1'b1, 1'b1, 5'd9, 6'd44, 6'd9, 4'hf);
    cyc();
    chk("v8_push_pending", 64'(fl_push), 64'b01);
    chk("v8_store_pending", 64'(store_committed), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("v8_rst_push", 64'(fl_push), 64'd0);
    chk("v8_rst_store", 64'(store_committed), 64'd0);
    chk("v8_rst_pop", 64'(rob_pop), 64'd0);
    chk("v8_rst_we", 64'(rrat_we), 64'd0);
`ifdef RETIRE_RVFI_EN
    chk("v8_rst_rvfi_valid", 64'(commit_rvfi[0].valid), 64'd0);
`endif
    cyc();
    chk("v8_rst_push_held", 64'(fl_push), 64'd0);
    rst_n = 1'b1;
    at_neg();
    chk("v8_pop_after", 64'(rob_pop), 64'b01);
    cyc(); idle();
    chk("v8_push_after", 64'(fl_push_reg[0]), 64'd9);
`ifdef RETIRE_RVFI_EN
    chk("v8_order_restart", commit_rvfi[0].order, 64'd0);
`endif
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
